// File: rtl/micron_psram_ctrl_pkg.sv
// rtl/micron_psram_ctrl_pkg.sv - shared constants and state encoding for the PSRAM controller
package micron_pkg;

  localparam logic [15:0] CMD_READ  = 16'hFFFA;
  localparam logic [15:0] CMD_WRITE = 16'hFFFB;
  localparam int unsigned LATENCY   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LAT,
    DATA
  } state_t;

endpackage

// File: rtl/micron_psram_ctrl_if.sv
// rtl/micron_psram_ctrl_if.sv - system bus and memory pin bundle of the PSRAM controller
interface micron_psram_ctrl_if;

  logic [15:0] baddr;
  logic [1:0]  bburst;
  logic        mwait;
  logic        bwait;
  logic [15:0] maddr;
  logic        mclk;
  logic        mce_L;
  logic        madv_L;
  logic        mwe_L;
  logic        moe_L;
  logic        mub_L;
  logic        mlb_L;
  logic        mcre;

  modport master (
    output baddr, bburst, mwait,
    input  bwait, maddr, mclk, mce_L, madv_L, mwe_L, moe_L, mub_L, mlb_L, mcre
  );

  modport slave (
    input  baddr, bburst, mwait,
    output bwait, maddr, mclk, mce_L, madv_L, mwe_L, moe_L, mub_L, mlb_L, mcre
  );

endinterface

// File: rtl/micron_psram_ctrl_count_reg.sv
// rtl/micron_psram_ctrl_count_reg.sv - 8-bit up-counter shared by the latency and beat counts
module count_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  output logic [7:0] count
);

  // load restarts the count from zero for the next phase
  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/micron_psram_ctrl.sv
// rtl/micron_psram_ctrl.sv - command decode, address, latency and burst pacing FSM
module micron_psram_ctrl #(
  parameter int unsigned LATENCY   = micron_pkg::LATENCY,
  parameter logic [15:0] CMD_READ  = micron_pkg::CMD_READ,
  parameter logic [15:0] CMD_WRITE = micron_pkg::CMD_WRITE
) (
  input  logic                 clk50MHz,
  input  logic                 rst,
  micron_psram_ctrl_if.slave   bus
);
  import micron_pkg::*;

  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

  state_t     state_q, state_d;
  logic       write_q, write_d;
  logic [1:0] burst_q, burst_d;
  logic       cnt_en, cnt_load;
  logic [7:0] count;

  logic        bwait_d, mce_d, madv_d, mwe_d, moe_d, ben_d;
  logic [15:0] maddr_d;

  count_reg u_count (
    .clk   (clk50MHz),
    .rst   (rst),
    .en    (cnt_en),
    .load  (cnt_load),
    .count (count)
  );

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      burst_q <= 2'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    burst_d  = burst_q;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    bwait_d  = 1'b0;
    maddr_d  = 16'h0000;
    mce_d    = 1'b1;
    madv_d   = 1'b1;
    mwe_d    = 1'b1;
    moe_d    = 1'b1;
    ben_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.baddr == CMD_READ || bus.baddr == CMD_WRITE) begin
          write_d = (bus.baddr == CMD_WRITE);
          burst_d = bus.bburst;
          state_d = ADDR;
        end
      end
      ADDR: begin
        maddr_d  = bus.baddr;
        mce_d    = 1'b0;
        madv_d   = 1'b0;
        ben_d    = 1'b0;
        mwe_d    = ~write_q;
        bwait_d  = 1'b1;
        cnt_load = 1'b1;
        state_d  = LAT;
      end
      LAT: begin
        mce_d   = 1'b0;
        ben_d   = 1'b0;
        moe_d   = write_q;
        bwait_d = 1'b1;
        if (count == LAT_LAST) begin
          cnt_load = 1'b1;
          state_d  = DATA;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DATA: begin
        mce_d   = 1'b0;
        ben_d   = 1'b0;
        moe_d   = write_q;
        bwait_d = bus.mwait;
        // a stalled beat neither counts nor ends the burst
        if (!bus.mwait) begin
          if (count == {6'd0, burst_q}) begin
            cnt_load = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bwait  = bwait_d;
  assign bus.maddr  = maddr_d;
  assign bus.mclk   = ~clk50MHz;
  assign bus.mce_L  = mce_d;
  assign bus.madv_L = madv_d;
  assign bus.mwe_L  = mwe_d;
  assign bus.moe_L  = moe_d;
  assign bus.mub_L  = ben_d;
  assign bus.mlb_L  = ben_d;
  assign bus.mcre   = 1'b0;

endmodule

// File: tb/tb_micron_psram_ctrl.sv
// tb/tb_micron_psram_ctrl.sv - directed self-checking bench for micron_psram_ctrl
module tb_micron_psram_ctrl;

  logic clk50MHz = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  micron_psram_ctrl_if bus ();

  micron_psram_ctrl dut (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .bus      (bus.slave)
  );

  always #10 clk50MHz = ~clk50MHz;

  // control vectors {mce, madv, mwe, moe, mub, mlb}
  localparam logic [5:0] C_IDLE = 6'b111111;
  localparam logic [5:0] C_WADR = 6'b000100;
  localparam logic [5:0] C_WACT = 6'b011100;
  localparam logic [5:0] C_RADR = 6'b001100;
  localparam logic [5:0] C_RACT = 6'b011000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {bus.mce_L, bus.madv_L, bus.mwe_L, bus.moe_L, bus.mub_L, bus.mlb_L};
  endfunction

  // one clock cycle: drive inputs just after the edge, check mid high phase
  task automatic cyc(input string tag, input logic [15:0] a, input logic [1:0] bl, input logic mw,
                     input logic [5:0] ec, input logic eb, input logic [15:0] ema);
    @(posedge clk50MHz);
    #2;
    bus.baddr  = a;
    bus.bburst = bl;
    bus.mwait  = mw;
    #5;
    chk({tag, ".ctl"}, 32'(ctl()), 32'(ec));
    chk({tag, ".bwait"}, 32'(bus.bwait), 32'(eb));
    chk({tag, ".maddr"}, 32'(bus.maddr), 32'(ema));
  endtask

  initial begin
    rst        = 1'b1;
    bus.baddr  = 16'h0000;
    bus.bburst = 2'd0;
    bus.mwait  = 1'b0;
    @(posedge clk50MHz);
    @(posedge clk50MHz);
    #7;
    chk("reset.ctl", 32'(ctl()), 32'(C_IDLE));
    chk("reset.bwait", 32'(bus.bwait), 32'd0);
    chk("reset.maddr", 32'(bus.maddr), 32'd0);
    chk("reset.mcre", 32'(bus.mcre), 32'd0);
    chk("reset.mclk", 32'(bus.mclk), 32'd0);
    rst = 1'b0;

    cyc("wr.c0", 16'hFFFB, 2'b11, 1'b0, C_IDLE, 1'b0, 16'h0000);
    cyc("wr.c1", 16'h00A5, 2'b00, 1'b0, C_WADR, 1'b1, 16'h00A5);
    for (int i = 2; i <= 5; i++) cyc("wr.lat", 16'h5555, 2'b00, 1'b0, C_WACT, 1'b1, 16'h0000);
    for (int i = 6; i <= 9; i++) cyc("wr.data", 16'h5555, 2'b00, 1'b0, C_WACT, 1'b0, 16'h0000);
    cyc("wr.c10", 16'h5555, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);

    cyc("rd.c0", 16'hFFFA, 2'b11, 1'b0, C_IDLE, 1'b0, 16'h0000);
    cyc("rd.c1", 16'h0000, 2'b00, 1'b0, C_RADR, 1'b1, 16'h0000);
    for (int i = 2; i <= 5; i++) cyc("rd.lat", 16'h5555, 2'b00, 1'b0, C_RACT, 1'b1, 16'h0000);
    for (int i = 6; i <= 9; i++) cyc("rd.data", 16'h5555, 2'b00, 1'b0, C_RACT, 1'b0, 16'h0000);
    cyc("rd.c10", 16'h5555, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);

    cyc("one.c0", 16'hFFFB, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);
    cyc("one.c1", 16'h0000, 2'b11, 1'b0, C_WADR, 1'b1, 16'h0000);
    for (int i = 2; i <= 5; i++) cyc("one.lat", 16'h5555, 2'b11, 1'b0, C_WACT, 1'b1, 16'h0000);
    cyc("one.c6", 16'h5555, 2'b11, 1'b0, C_WACT, 1'b0, 16'h0000);
    cyc("one.c7", 16'h5555, 2'b11, 1'b0, C_IDLE, 1'b0, 16'h0000);

    cyc("stl.c0", 16'hFFFB, 2'b11, 1'b0, C_IDLE, 1'b0, 16'h0000);
    cyc("stl.c1", 16'h0000, 2'b00, 1'b1, C_WADR, 1'b1, 16'h0000);
    for (int i = 2; i <= 5; i++) cyc("stl.lat", 16'h5555, 2'b00, 1'b1, C_WACT, 1'b1, 16'h0000);
    cyc("stl.c6", 16'h5555, 2'b00, 1'b0, C_WACT, 1'b0, 16'h0000);
    cyc("stl.c7", 16'h5555, 2'b00, 1'b1, C_WACT, 1'b1, 16'h0000);
    cyc("stl.c8", 16'h5555, 2'b00, 1'b1, C_WACT, 1'b1, 16'h0000);
    for (int i = 9; i <= 11; i++) cyc("stl.data", 16'h5555, 2'b00, 1'b0, C_WACT, 1'b0, 16'h0000);
    cyc("stl.c12", 16'h5555, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);

    cyc("rst.c0", 16'hFFFB, 2'b11, 1'b0, C_IDLE, 1'b0, 16'h0000);
    cyc("rst.c1", 16'h0000, 2'b00, 1'b0, C_WADR, 1'b1, 16'h0000);
    cyc("rst.c2", 16'h5555, 2'b00, 1'b0, C_WACT, 1'b1, 16'h0000);
    cyc("rst.c3", 16'h5555, 2'b00, 1'b0, C_WACT, 1'b1, 16'h0000);
    rst = 1'b1;
    cyc("rst.c4", 16'h5555, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);
    rst = 1'b0;
    cyc("rst.c5", 16'hFFFA, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);
    cyc("rst.c6", 16'h0000, 2'b00, 1'b0, C_RADR, 1'b1, 16'h0000);
    for (int i = 7; i <= 10; i++) cyc("rst.lat", 16'h5555, 2'b00, 1'b0, C_RACT, 1'b1, 16'h0000);
    cyc("rst.c11", 16'h5555, 2'b00, 1'b0, C_RACT, 1'b0, 16'h0000);
    cyc("rst.c12", 16'h5555, 2'b00, 1'b0, C_IDLE, 1'b0, 16'h0000);

    for (int i = 0; i < 4; i++) cyc("noncmd", 16'h1234, 2'b11, 1'b1, C_IDLE, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
